song_sequencer: RTL and testbench

SONG_SEQUENCER -- requirements
Module: song_sequencer

---
 rtl/song_sequencer_pkg.sv | 46 ++++
 rtl/song_sequencer_dur_counter.sv | 38 +++
 rtl/song_sequencer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_song_sequencer.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : song_sequencer_pkg                                     |
// | Description : Shared mode/state encodings, ROM word layout and field |
// |               helpers for the song sequencer and the mode FSM.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package song_sequencer_pkg;

    // One-hot operating modes produced by the mode FSM
    localparam logic [2:0] c_MODE_FREE  = 3'b001;
    localparam logic [2:0] c_MODE_AUTO  = 3'b010;
    localparam logic [2:0] c_MODE_LEARN = 3'b100;

    // ROM word layout: [7:3] note code, [2:0] duration code
    localparam int c_NOTE_MSB = 7;
    localparam int c_NOTE_LSB = 3;
    localparam int c_DUR_MSB  = 2;
    localparam int c_DUR_LSB  = 0;
    localparam int c_NOTE_W   = c_NOTE_MSB - c_NOTE_LSB + 1;
    localparam int c_DUR_W    = c_DUR_MSB - c_DUR_LSB + 1;

    // An all-zero word terminates a song
    localparam logic [7:0] c_END_MARKER = 8'h00;

    // Sequencer states, explicitly encoded
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_LOAD     = 3'd2,
        S_PLAY     = 3'd3,
        S_GAP      = 3'd4,
        S_WAIT_KEY = 3'd5,
        S_PAUSED   = 3'd6
    } seq_state_t;

    function automatic logic [c_NOTE_W-1:0] rom_note(input logic [7:0] word);
        return word[c_NOTE_MSB:c_NOTE_LSB];
    endfunction

    function automatic logic [c_DUR_W-1:0] rom_dur(input logic [7:0] word);
        return word[c_DUR_MSB:c_DUR_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/song_sequencer_dur_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dur_counter                                            |
// | Description : Tick-driven down-counter with load, hold and zero      |
// |               flag; times both note and gap intervals.               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module dur_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_hold,
    input  logic             i_tick,
    output logic [CNT_W-1:0] o_count,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // Load has priority; otherwise consume one tick unless held or empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_tick && !i_hold && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/song_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : song_sequencer                                         |
// | Description : Plays songs from ROM in auto-play mode, or waits for   |
// |               matching key presses in learning mode and scores them. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module song_sequencer
    import song_sequencer_pkg::*;
#(
    parameter int GAP_TICKS = 1,
    parameter int IDX_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic             start,
    input  logic             pause,
    input  logic             tick,
    input  logic [1:0]       song_sel,
    output logic [IDX_W+1:0] rom_addr,
    input  logic [7:0]       rom_data,
    input  logic [4:0]       key_code,
    input  logic             key_valid,
    output logic [4:0]       note_out,
    output logic             note_en,
    output logic [4:0]       led_expect,
    output logic             busy,
    output logic             done,
    output logic [7:0]       hit_cnt,
    output logic [7:0]       miss_cnt
);

    localparam int c_GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam int c_CNT_W = (c_GAP_W > c_DUR_W + 1) ? c_GAP_W : c_DUR_W + 1;

    seq_state_t          r_state;
    seq_state_t          r_saved;
    logic [2:0]          r_mode;
    logic [1:0]          r_song;
    logic [IDX_W-1:0]    r_idx;
    logic [c_NOTE_W-1:0] r_note;
    logic [c_DUR_W-1:0]  r_dur;
    logic [IDX_W+1:0]    r_rom_addr;
    logic [4:0]          r_note_out;
    logic                r_note_en;
    logic [4:0]          r_led;
    logic                r_busy;
    logic                r_done;
    logic [7:0]          r_hit;
    logic [7:0]          r_miss;

    logic [c_NOTE_W-1:0] w_rom_note;
    logic [c_DUR_W-1:0]  w_rom_dur;
    logic                w_abort;
    logic                w_start_ok;
    logic                w_tick_eff;
    logic                w_key_hit;
    logic                w_idx_last;
    logic [IDX_W-1:0]    w_idx_next;
    logic                w_cnt_load;
    logic [c_CNT_W-1:0]  w_cnt_val;
    logic                w_cnt_hold;
    logic [c_CNT_W-1:0]  w_cnt;
    logic                w_cnt_zero;
    logic                w_cnt_one;
    logic                w_play_end;
    logic                w_gap_done;

    assign w_rom_note = rom_note(rom_data);
    assign w_rom_dur  = rom_dur(rom_data);
    assign w_abort    = (r_state != S_IDLE) && (mode != r_mode);
    assign w_start_ok = start && ((mode == c_MODE_AUTO) || (mode == c_MODE_LEARN));
    // A pause in the same cycle as a tick swallows the tick
    assign w_tick_eff = tick && !pause;
    assign w_key_hit  = key_valid && (key_code == r_note);
    assign w_idx_last = &r_idx;
    assign w_idx_next = r_idx + IDX_W'(1);
    assign w_cnt_one  = (w_cnt == c_CNT_W'(1));
    assign w_play_end = w_tick_eff && w_cnt_one;
    // A zero-length gap finishes immediately
    assign w_gap_done = w_cnt_zero || (w_tick_eff && w_cnt_one);
    assign w_cnt_hold = pause || !((r_state == S_PLAY) || (r_state == S_GAP));

    // Reload the interval counter when a note, rest or gap begins
    always_comb begin
        w_cnt_load = 1'b0;
        w_cnt_val  = '0;
        case (r_state)
            S_LOAD: begin
                if ((r_mode == c_MODE_AUTO) && (rom_data != c_END_MARKER)) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = c_CNT_W'(w_rom_dur) + c_CNT_W'(1);
                end
            end
            S_WAIT_KEY: begin
                if (!pause && w_key_hit) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = c_CNT_W'(r_dur) + c_CNT_W'(1);
                end
            end
            S_PLAY: begin
                if (!pause && w_play_end) begin
                    w_cnt_load = 1'b1;
                    w_cnt_val  = c_CNT_W'(GAP_TICKS);
                end
            end
            default: begin
                w_cnt_load = 1'b0;
            end
        endcase
    end

    dur_counter #(
        .CNT_W (c_CNT_W)
    ) u_dur_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_val),
        .i_hold     (w_cnt_hold),
        .i_tick     (w_tick_eff),
        .o_count    (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_saved    <= S_IDLE;
            r_mode     <= 3'b000;
            r_song     <= 2'b00;
            r_idx      <= '0;
            r_note     <= '0;
            r_dur      <= '0;
            r_rom_addr <= '0;
            r_note_out <= '0;
            r_note_en  <= 1'b0;
            r_led      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_hit      <= '0;
            r_miss     <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                // Mode changed under us: stop silently, keep the scores
                r_state   <= S_IDLE;
                r_busy    <= 1'b0;
                r_note_en <= 1'b0;
                r_led     <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start_ok) begin
                            r_mode     <= mode;
                            r_song     <= song_sel;
                            r_idx      <= '0;
                            r_rom_addr <= {song_sel, {IDX_W{1'b0}}};
                            r_hit      <= '0;
                            r_miss     <= '0;
                            r_busy     <= 1'b1;
                            r_state    <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        r_state <= S_LOAD;
                    end
                    S_LOAD: begin
                        r_note <= w_rom_note;
                        r_dur  <= w_rom_dur;
                        if (rom_data == c_END_MARKER) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else if (r_mode == c_MODE_LEARN) begin
                            if (w_rom_note == '0) begin
                                // Rests are skipped when learning
                                if (w_idx_last) begin
                                    r_done  <= 1'b1;
                                    r_busy  <= 1'b0;
                                    r_state <= S_IDLE;
                                end else begin
                                    r_idx      <= w_idx_next;
                                    r_rom_addr <= {r_song, w_idx_next};
                                    r_state    <= S_FETCH;
                                end
                            end else begin
                                r_led   <= w_rom_note;
                                r_state <= S_WAIT_KEY;
                            end
                        end else begin
                            // Rests play silently for their duration
                            r_note_out <= w_rom_note;
                            r_note_en  <= (w_rom_note != '0);
                            r_state    <= S_PLAY;
                        end
                    end
                    S_PLAY: begin
                        if (pause) begin
                            r_saved   <= S_PLAY;
                            r_note_en <= 1'b0;
                            r_state   <= S_PAUSED;
                        end else if (w_play_end) begin
                            r_note_en <= 1'b0;
                            r_state   <= S_GAP;
                        end
                    end
                    S_GAP: begin
                        if (pause) begin
                            r_saved <= S_GAP;
                            r_state <= S_PAUSED;
                        end else if (w_gap_done) begin
                            if (w_idx_last) begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_IDLE;
                            end else begin
                                r_idx      <= w_idx_next;
                                r_rom_addr <= {r_song, w_idx_next};
                                r_state    <= S_FETCH;
                            end
                        end
                    end
                    S_WAIT_KEY: begin
                        if (pause) begin
                            r_saved <= S_WAIT_KEY;
                            r_state <= S_PAUSED;
                        end else if (key_valid) begin
                            if (w_key_hit) begin
                                r_hit      <= (r_hit == 8'hFF) ? r_hit : r_hit + 8'd1;
                                r_led      <= '0;
                                r_note_out <= r_note;
                                r_note_en  <= 1'b1;
                                r_state    <= S_PLAY;
                            end else begin
                                r_miss <= (r_miss == 8'hFF) ? r_miss : r_miss + 8'd1;
                            end
                        end
                    end
                    S_PAUSED: begin
                        if (pause) begin
                            r_state   <= r_saved;
                            r_note_en <= (r_saved == S_PLAY) && (r_note != '0);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rom_addr   = r_rom_addr;
    assign note_out   = r_note_out;
    assign note_en    = r_note_en;
    assign led_expect = r_led;
    assign busy       = r_busy;
    assign done       = r_done;
    assign hit_cnt    = r_hit;
    assign miss_cnt   = r_miss;

endmodule
`default_nettype wire

// File: tb/tb_song_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_song_sequencer                                      |
// | Description : Scoreboard bench; expected note segments and end-of-   |
// |               song events are queued and matched by a monitor.       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_song_sequencer;

    localparam int GAP = 1;
    localparam int IDXW = 6;

    logic       clk;
    logic       rst;
    logic [2:0] mode;
    logic       start;
    logic       pause;
    logic       tick;
    logic [1:0] song_sel;
    logic [7:0] rom_addr;
    logic [7:0] rom_data;
    logic [4:0] key_code;
    logic       key_valid;
    logic [4:0] note_out;
    logic       note_en;
    logic [4:0] led_expect;
    logic       busy;
    logic       done;
    logic [7:0] hit_cnt;
    logic [7:0] miss_cnt;

    song_sequencer #(.GAP_TICKS(GAP), .IDX_W(IDXW)) dut (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .pause(pause),
        .tick(tick), .song_sel(song_sel), .rom_addr(rom_addr), .rom_data(rom_data),
        .key_code(key_code), .key_valid(key_valid), .note_out(note_out),
        .note_en(note_en), .led_expect(led_expect), .busy(busy), .done(done),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Synchronous song ROM: word appears one cycle after its address
    logic [7:0] rom [0:255];
    always @(posedge clk) rom_data <= rom[rom_addr];

    // Tick strobe every 5th cycle, updated just after each rising edge
    int cyc;
    initial begin
        tick = 1'b0;
        cyc  = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            tick = (cyc % 5 == 0);
        end
    end

    typedef struct {
        bit is_done;
        int note;
        int ticks;
        int pre;     // silent busy ticks before this event, -1 = don't care
    } exp_t;

    exp_t       expq[$];
    logic [7:0] song_q[$];
    int total = 0;
    int bad   = 0;
    int cur_song = 0;
    bit mon_en = 0;
    bit in_seg = 0;
    int seg_note, seg_ticks, seg_pre;
    int pre_ticks = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_seg(input int n, input int t, input int p);
        exp_t e;
        e.is_done = 0; e.note = n; e.ticks = t; e.pre = p;
        expq.push_back(e);
    endtask

    task automatic push_done(input int p);
        exp_t e;
        e.is_done = 1; e.note = 0; e.ticks = 0; e.pre = p;
        expq.push_back(e);
    endtask

    task automatic close_seg();
        exp_t e;
        if (expq.size() == 0) begin
            total++; bad++;
            $display("FAIL seg_unexpected: got note %0d ticks %0d expected no event", seg_note, seg_ticks);
        end else begin
            e = expq.pop_front();
            check("event_kind_seg", 0, int'(e.is_done));
            check("seg_note", seg_note, e.note);
            check("seg_ticks", seg_ticks, e.ticks);
            if (e.pre >= 0) check("seg_pre_ticks", seg_pre, e.pre);
        end
    endtask

    task automatic close_done();
        exp_t e;
        if (expq.size() == 0) begin
            total++; bad++;
            $display("FAIL done_unexpected: got done=1 expected no event");
        end else begin
            e = expq.pop_front();
            check("event_kind_done", 1, int'(e.is_done));
            if (e.pre >= 0) check("done_pre_ticks", pre_ticks, e.pre);
        end
    endtask

    // Monitor: turns note_en intervals and done pulses into events
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy) check("rom_block", int'(rom_addr[7:6]), cur_song);
            if (note_en) begin
                if (!in_seg) begin
                    in_seg = 1; seg_note = note_out; seg_ticks = 0; seg_pre = pre_ticks;
                end
                if (tick && !pause) seg_ticks++;
            end else begin
                if (in_seg) begin
                    in_seg = 0;
                    close_seg();
                    pre_ticks = 0;
                end
                if (busy && tick && !pause) pre_ticks++;
            end
            if (done) close_done();
            if (!busy) pre_ticks = 0;
        end
    end

    // Reference model: what a listener should hear for song_q
    task automatic model_song(input bit learn);
        int p;
        logic [7:0] e;
        int n, d;
        p = 0;
        foreach (song_q[i]) begin
            e = song_q[i];
            n = int'(e[7:3]);
            d = int'(e[2:0]);
            if (n == 0) begin
                if (!learn) p = p + d + 1 + GAP;
            end else begin
                push_seg(n, d + 1, learn ? -1 : p);
                p = GAP;
            end
        end
        push_done(learn ? -1 : p);
    endtask

    task automatic load_rom(input int s);
        for (int i = 0; i < 64; i++)
            rom[s * 64 + i] = (i < song_q.size()) ? song_q[i] : 8'h00;
    endtask

    task automatic start_song();
        do begin @(posedge clk); #2; end while (!tick);
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (busy && n < limit) begin @(posedge clk); #2; n++; end
        if (busy) begin
            total++; bad++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0 within %0d cycles", limit);
        end
        @(posedge clk); #2;
    endtask

    task automatic wait_note_tick(input int limit);
        int n;
        n = 0;
        while (!(note_en && tick) && n < limit) begin @(posedge clk); #2; n++; end
        if (!(note_en && tick)) begin
            total++; bad++;
            $display("FAIL note_timeout: got note_en=%0d expected a ticked note", note_en);
        end
    endtask

    task automatic press_key(input logic [4:0] k);
        @(posedge clk); #2 key_code = k; key_valid = 1'b1;
        @(posedge clk); #2 key_valid = 1'b0;
    endtask

    // Learning player: wrong keys (fixed count, or random if negative), then the right one
    task automatic play_keys(input int nwrong_fixed, inout int hits, inout int misses);
        logic [7:0] e;
        logic [4:0] n;
        int nw, w;
        foreach (song_q[i]) begin
            e = song_q[i];
            n = e[7:3];
            if (n != 5'd0) begin
                w = 0;
                while (led_expect == 5'd0 && w < 400) begin @(posedge clk); #2; w++; end
                check("led_expect", int'(led_expect), int'(n));
                nw = (nwrong_fixed >= 0) ? nwrong_fixed : int'($urandom_range(0, 2));
                for (int k = 0; k < nw; k++) begin
                    press_key((nwrong_fixed >= 0) ? (n ^ 5'd7) : (n ^ 5'($urandom_range(1, 31))));
                    misses = (misses < 255) ? misses + 1 : 255;
                end
                press_key(n);
                hits = (hits < 255) ? hits + 1 : 255;
            end
        end
    endtask

    task automatic run_song(input int s, input bit learn, input int nwrong);
        int hits, misses;
        hits = 0; misses = 0;
        load_rom(s);
        model_song(learn);
        mode = learn ? 3'b100 : 3'b010;
        song_sel = 2'(s);
        cur_song = s;
        start_song();
        if (learn) play_keys(nwrong, hits, misses);
        wait_idle(6000);
        check("events_left", expq.size(), 0);
        check("hit_cnt", int'(hit_cnt), hits);
        check("miss_cnt", int'(miss_cnt), misses);
        expq.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rom_addr"}, int'(rom_addr), 0);
        check({tag, "_note_out"}, int'(note_out), 0);
        check({tag, "_note_en"}, int'(note_en), 0);
        check({tag, "_led_expect"}, int'(led_expect), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_hit_cnt"}, int'(hit_cnt), 0);
        check({tag, "_miss_cnt"}, int'(miss_cnt), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_paused, tk;
        logic [7:0] e;
        rst = 1'b1; mode = 3'b010; start = 0; pause = 0; song_sel = 0;
        key_code = 0; key_valid = 0;
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
        #3 rst = 1'b0;
        #1 check_zero_outputs("reset");
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        mon_en = 1;

        // Basic auto-play: note 5 for 2 ticks, note 7 for 1 tick
        song_q = '{8'h29, 8'h38};
        run_song(0, 0, 0);

        // Start is ignored in free mode
        mode = 3'b001;
        start_song();
        check("free_start_busy", int'(busy), 0);

        // Learning: wrong key 4 then correct key 3
        song_q = '{8'h19};
        run_song(1, 1, 1);

        // Pause after 1 of 4 ticks, hold for 10 ticks, resume for 3 more
        song_q = '{8'h53};
        load_rom(2);
        push_seg(10, 1, 0); push_seg(10, 3, 10); push_done(1);
        mode = 3'b010; song_sel = 2; cur_song = 2;
        start_song();
        wait_note_tick(50);
        @(posedge clk); #2 pause = 1'b1;
        @(posedge clk); #2 pause = 1'b0;
        en_paused = 0; tk = 0;
        while (tk < 10) begin
            if (note_en) en_paused++;
            if (tick) tk++;
            @(posedge clk); #2;
        end
        pause = 1'b1;
        @(posedge clk); #2 pause = 1'b0;
        wait_idle(200);
        check("paused_note_en_cycles", en_paused, 0);
        check("pause_events_left", expq.size(), 0);
        expq.delete();

        // Abort mid-note by switching to free mode: no done pulse
        song_q = '{8'h67};
        load_rom(3);
        push_seg(12, 1, 0);
        mode = 3'b010; song_sel = 3; cur_song = 3;
        start_song();
        wait_note_tick(50);
        @(posedge clk); #2 mode = 3'b001;
        @(posedge clk); #2;
        check("abort_note_en", int'(note_en), 0);
        check("abort_busy", int'(busy), 0);
        repeat (20) @(posedge clk);
        #2 check("abort_events_left", expq.size(), 0);
        expq.delete();
        mode = 3'b010;

        // Index wrap: 64 sounding entries, no end marker
        song_q.delete();
        for (int i = 0; i < 64; i++) begin
            e = {5'($urandom_range(1, 31)), 3'($urandom_range(0, 1))};
            song_q.push_back(e);
        end
        rom[128] = 8'hF8;
        run_song(1, 0, 0);

        // Miss counter saturates at 255
        song_q = '{8'h48};
        run_song(0, 1, 260);

        // Randomized songs in both modes
        for (int it = 0; it < 6; it++) begin
            song_q.delete();
            for (int i = 0; i < int'($urandom_range(1, 10)); i++) begin
                e[7:3] = 5'($urandom_range(0, 31));
                e[2:0] = (e[7:3] == 5'd0) ? 3'($urandom_range(1, 7)) : 3'($urandom_range(0, 7));
                song_q.push_back(e);
            end
            run_song(int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), -1);
        end

        // Asynchronous reset in the middle of a note, then replay from idx 0
        song_q = '{8'h33};
        load_rom(2);
        mode = 3'b010; song_sel = 2; cur_song = 2;
        start_song();
        wait_note_tick(50);
        @(posedge clk); #4;
        mon_en = 0;
        rst = 1'b0;
        #1 check_zero_outputs("async_rst");
        expq.delete(); in_seg = 0; pre_ticks = 0;
        @(posedge clk); #3 rst = 1'b1;
        mon_en = 1;
        run_song(2, 0, 0);

        check("final_events_left", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
